// File: rtl/draw_scheduler.sv
// draw_scheduler
// Shares the single VGA pixel-write port among N draw requesters. The winner's
// rectangle is rastered row-major; rom_addr comes straight from the address
// counter, and plot/x_out/y_out are registered one cycle later so they line up
// with the ROM's 1-cycle read data.
//
// Configuration macro: DRAW_SCHED_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration (search starts after the last grant)
//   undefined -> fixed priority, lowest index wins
//
// Ports
//   Clock, Resetn      clock, asynchronous active-low reset
//   req[N]             level request per requester, held until its done pulse
//   req_x/y/w/h/base   packed per-requester rectangle origin, size, ROM base
//   stall              freezes the raster while drawing
//   grant[N]           one-hot, from latch through the done cycle
//   busy               any grant active
//   rom_addr           sprite ROM read address
//   plot, x_out, y_out registered VGA write strobe and coordinates
//   done[N]            one-cycle completion pulse to the served requester
//
// state | meaning
// IDLE  | waiting for a request; latches the winner's geometry
// DRAW  | one pixel per unstalled cycle
// DONE  | done pulse, last pixel's plot visible; grant released on exit

module draw_scheduler #(
  parameter int N      = 4,
  parameter int ADDR_W = 15,
  parameter int X_MAX  = 160,
  parameter int Y_MAX  = 120
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [N-1:0]        req,
  input  logic [8*N-1:0]      req_x,
  input  logic [7*N-1:0]      req_y,
  input  logic [8*N-1:0]      req_w,
  input  logic [7*N-1:0]      req_h,
  input  logic [ADDR_W*N-1:0] req_base,
  input  logic                stall,
  output logic [N-1:0]        grant,
  output logic                busy,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic                plot,
  output logic [7:0]          x_out,
  output logic [6:0]          y_out,
  output logic [N-1:0]        done
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [8:0] X_LIM = 9'(X_MAX);
  localparam logic [7:0] Y_LIM = 8'(Y_MAX);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t              state_q;
  logic [N-1:0]        grant_q, done_q;
  logic [7:0]          ox_q, w_q, cx_q, x_out_q;
  logic [6:0]          oy_q, h_q, cy_q, y_out_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                plot_q;

  logic                win_any_d;
  logic [IDX_W-1:0]    win_idx_d;
  logic [N-1:0]        win_oh_d;
  logic [8:0]          xs_d;
  logic [7:0]          ys_d;
  logic                last_col_d, last_row_d;

`ifdef DRAW_SCHED_ROUND_ROBIN_EN
  logic [IDX_W-1:0]    rr_q;

  always_comb begin
    win_any_d = 1'b0;
    win_idx_d = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_any_d && req[(int'(rr_q) + k) % N]) begin
        win_any_d = 1'b1;
        win_idx_d = IDX_W'((int'(rr_q) + k) % N);
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rr_q <= '0;
    end else if (state_q == IDLE && win_any_d) begin
      if (int'(win_idx_d) == N - 1) rr_q <= '0;
      else                          rr_q <= win_idx_d + 1'b1;
    end
  end
`else
  // Descending scan so the lowest requesting index is the last assignment.
  always_comb begin
    win_any_d = 1'b0;
    win_idx_d = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_any_d = 1'b1;
        win_idx_d = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    win_oh_d = '0;
    if (win_any_d) win_oh_d[win_idx_d] = 1'b1;
  end

  // Widened sums so off-screen pixels are clipped instead of wrapping back on.
  assign xs_d       = {1'b0, ox_q} + {1'b0, cx_q};
  assign ys_d       = {1'b0, oy_q} + {1'b0, cy_q};
  assign last_col_d = (cx_q == w_q - 8'd1);
  assign last_row_d = (cy_q == h_q - 7'd1);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      plot_q  <= 1'b0;
      x_out_q <= '0;
      y_out_q <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      addr_q  <= '0;
    end else begin
      done_q <= '0;
      plot_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_any_d) begin
            ox_q    <= req_x[8*win_idx_d +: 8];
            oy_q    <= req_y[7*win_idx_d +: 7];
            w_q     <= req_w[8*win_idx_d +: 8];
            h_q     <= req_h[7*win_idx_d +: 7];
            addr_q  <= req_base[ADDR_W*win_idx_d +: ADDR_W];
            cx_q    <= '0;
            cy_q    <= '0;
            grant_q <= win_oh_d;
            if (req_w[8*win_idx_d +: 8] == 8'd0 || req_h[7*win_idx_d +: 7] == 7'd0) begin
              done_q  <= win_oh_d;
              state_q <= DONE;
            end else begin
              state_q <= DRAW;
            end
          end
        end
        DRAW: begin
          if (!stall) begin
            plot_q  <= (xs_d < X_LIM) && (ys_d < Y_LIM);
            x_out_q <= xs_d[7:0];
            y_out_q <= ys_d[6:0];
            addr_q  <= addr_q + 1'b1;
            if (last_col_d) begin
              cx_q <= '0;
              cy_q <= cy_q + 7'd1;
              if (last_row_d) begin
                done_q  <= grant_q;
                state_q <= DONE;
              end
            end else begin
              cx_q <= cx_q + 8'd1;
            end
          end
        end
        DONE: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign busy     = |grant_q;
  assign rom_addr = addr_q;
  assign plot     = plot_q;
  assign x_out    = x_out_q;
  assign y_out    = y_out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;

  localparam int N = 4;
  localparam int AW = 15;

  logic          Clock, Resetn;
  logic [N-1:0]  req;
  logic [8*N-1:0] req_x, req_w;
  logic [7*N-1:0] req_y, req_h;
  logic [AW*N-1:0] req_base;
  logic          stall;
  logic [N-1:0]  grant, done;
  logic          busy, plot;
  logic [AW-1:0] rom_addr;
  logic [7:0]    x_out;
  logic [6:0]    y_out;

  int checks = 0;
  int failures = 0;

  // Stall scenario, indexed by cycle after latch minus one.
  localparam int ST_ROM  [9] = '{50, 51, 51, 51, 51, 52, 53, 0, 0};
  localparam int ST_PLOT [9] = '{0, 1, 0, 0, 0, 1, 1, 1, 0};
  localparam int ST_X    [9] = '{0, 1, 0, 0, 0, 2, 1, 2, 0};
  localparam int ST_Y    [9] = '{0, 2, 0, 0, 0, 2, 3, 3, 0};

  draw_scheduler #(.N(N), .ADDR_W(AW), .X_MAX(160), .Y_MAX(120)) dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_base(req_base), .stall(stall),
    .grant(grant), .busy(busy), .rom_addr(rom_addr), .plot(plot),
    .x_out(x_out), .y_out(y_out), .done(done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    req    = '0;
    stall  = 1'b0;
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
  endtask

  task automatic set_req(input int i, input int x, input int y, input int w,
                         input int h, input int base);
    req_x[8*i +: 8]     = 8'(x);
    req_y[7*i +: 7]     = 7'(y);
    req_w[8*i +: 8]     = 8'(w);
    req_h[7*i +: 7]     = 7'(h);
    req_base[AW*i +: AW] = AW'(base);
  endtask

  initial begin
    int got [4];
    int exp_seq [4];
    int n;

    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_base = '0;
    req = '0; stall = 1'b0; Resetn = 1'b0;
    #3;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_plot", plot, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_busy", busy, 0);
    tick();
    Resetn = 1'b1;

    // 3x2 rectangle from requester 1
    set_req(1, 10, 20, 3, 2, 100);
    req[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t1_grant", grant, (k <= 7) ? 2 : 0);
      check("t1_done", done, (k == 7) ? 2 : 0);
      check("t1_plot", plot, (k >= 2 && k <= 7) ? 1 : 0);
      if (k <= 6) check("t1_addr", rom_addr, 100 + k - 1);
      if (k >= 2 && k <= 7) begin
        check("t1_x", x_out, 10 + (k - 2) % 3);
        check("t1_y", y_out, 20 + (k - 2) / 3);
      end
      if (k == 7) req[1] = 1'b0;
    end

    // arbitration between 0 and 2, both held
    do_reset();
    set_req(0, 1, 1, 1, 1, 0);
    set_req(2, 2, 2, 1, 1, 10);
`ifdef DRAW_SCHED_ROUND_ROBIN_EN
    exp_seq = '{1, 4, 1, 4};
`else
    exp_seq = '{1, 1, 1, 1};
`endif
    req[0] = 1'b1;
    req[2] = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (done != 0) begin
        got[n] = int'(done);
        n++;
      end
    end
    check("arb_count", n, 4);
    for (int i = 0; i < 4; i++)
      if (i < n) check("arb_winner", got[i], exp_seq[i]);

    // right-edge clipping plus ROM address wrap
    do_reset();
    set_req(3, 158, 5, 4, 1, 32766);
    req[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("clip_grant", grant, (k <= 5) ? 8 : 0);
      check("clip_done", done, (k == 5) ? 8 : 0);
      check("clip_plot", plot, (k == 2 || k == 3) ? 1 : 0);
      if (k <= 4) check("clip_addr", rom_addr, (32766 + k - 1) % 32768);
      if (k == 2 || k == 3) check("clip_x", x_out, 158 + k - 2);
      if (k == 5) req[3] = 1'b0;
    end

    // zero-width rectangle
    do_reset();
    set_req(2, 5, 5, 0, 3, 7);
    req[2] = 1'b1;
    tick();
    check("w0_done", done, 4);
    check("w0_busy1", busy, 1);
    check("w0_plot1", plot, 0);
    req[2] = 1'b0;
    tick();
    check("w0_busy2", busy, 0);
    check("w0_done2", done, 0);
    check("w0_plot2", plot, 0);

    // 2x2 with stall for three cycles after the first pixel
    do_reset();
    set_req(0, 1, 2, 2, 2, 50);
    req[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("st_grant", grant, (k <= 8) ? 1 : 0);
      check("st_done", done, (k == 8) ? 1 : 0);
      check("st_plot", plot, ST_PLOT[k-1]);
      if (k <= 7) check("st_addr", rom_addr, ST_ROM[k-1]);
      if (ST_PLOT[k-1] == 1) begin
        check("st_x", x_out, ST_X[k-1]);
        check("st_y", y_out, ST_Y[k-1]);
      end
      if (k == 2) stall = 1'b1;
      if (k == 5) stall = 1'b0;
      if (k == 8) req[0] = 1'b0;
    end

    // reset during the second pixel of a 4x4 draw, request kept high
    do_reset();
    set_req(1, 0, 0, 4, 4, 200);
    req[1] = 1'b1;
    tick();
    tick();
    tick();
    check("mr_plot_pre", plot, 1);
    check("mr_x_pre", x_out, 1);
    Resetn = 1'b0;
    #1;
    check("mr_plot", plot, 0);
    check("mr_grant", grant, 0);
    check("mr_done", done, 0);
    check("mr_busy", busy, 0);
    #2;
    Resetn = 1'b1;
    tick();
    check("mr_regrant", grant, 2);
    check("mr_addr0", rom_addr, 200);
    tick();
    check("mr_plot0", plot, 1);
    check("mr_x0", x_out, 0);
    check("mr_y0", y_out, 0);
    check("mr_addr1", rom_addr, 201);
    req[1] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
